// File: rtl/vga_axi_regfile.sv
// AXI4-Lite register file for VGA-class peripherals: byte-strobed R/W control registers,
// read-only status words from the core, SLVERR decode and one-cycle per-register write pulses.
module vga_axi_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 16,
  parameter int NUM_RO_REGS        = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
  input  logic [((NUM_RO_REGS > 0) ? NUM_RO_REGS : 1)*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]                    wr_pulse
);
  localparam int DW        = C_S_AXI_DATA_WIDTH;
  localparam int AW        = C_S_AXI_ADDR_WIDTH;
  localparam int ADDRLSB   = (DW == 64) ? 3 : 2;
  localparam int IDX_W     = AW - ADDRLSB;
  localparam int NUM_RW    = NUM_REGS - NUM_RO_REGS;
  localparam int NUM_BYTES = DW / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t            w_state, w_state_d;
  r_state_t            r_state, r_state_d;
  logic                aw_ready, aw_ready_d;
  logic                b_valid, b_valid_d;
  logic [1:0]          b_resp, b_resp_d;
  logic                ar_ready, ar_ready_d;
  logic                r_valid, r_valid_d;
  logic [1:0]          r_resp, r_resp_d;
  logic [DW-1:0]       r_data, r_data_d;
  logic [NUM_REGS-1:0] wr_pulse_d;
  logic [IDX_W-1:0]    aw_idx, ar_idx;
  logic                wr_fire, wr_ok, rd_ok;
  logic [DW-1:0]       rd_word;
  logic                unused_inputs;

  assign aw_idx  = S_AXI_AWADDR[AW-1:ADDRLSB];
  assign ar_idx  = S_AXI_ARADDR[AW-1:ADDRLSB];
  assign wr_fire = aw_ready && S_AXI_AWVALID && S_AXI_WVALID;
  assign wr_ok   = (int'(aw_idx) < NUM_RW);

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDRLSB-1:0],
                           S_AXI_ARADDR[ADDRLSB-1:0], status_in};

  // Register storage: R/W slots are flops, RO slots pass the core's status straight through.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i < NUM_RW) begin : g_rw
      logic [DW-1:0] q;
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          q <= '0;
        end else if (wr_fire && (int'(aw_idx) == i)) begin
          for (int b = 0; b < NUM_BYTES; b++) begin
            if (S_AXI_WSTRB[b]) q[b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
          end
        end
      end
      assign ctrl_regs[i*DW +: DW] = q;
    end else begin : g_ro
      assign ctrl_regs[i*DW +: DW] = status_in[(i-NUM_RW)*DW +: DW];
    end
  end

  always_comb begin
    rd_word = '0;
    rd_ok   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(ar_idx) == i) begin
        rd_word = ctrl_regs[i*DW +: DW];
        rd_ok   = 1'b1;
      end
    end
  end

  // Write channel: ready is registered, so both valids must be seen one cycle before acceptance.
  always_comb begin
    w_state_d  = w_state;
    aw_ready_d = 1'b0;
    b_valid_d  = b_valid;
    b_resp_d   = b_resp;
    wr_pulse_d = '0;
    case (w_state)
      W_IDLE: begin
        if (aw_ready) begin
          if (wr_fire) begin
            w_state_d = W_RESP;
            b_valid_d = 1'b1;
            b_resp_d  = wr_ok ? RESP_OKAY : RESP_SLVERR;
            for (int i = 0; i < NUM_REGS; i++) begin
              wr_pulse_d[i] = wr_ok && (int'(aw_idx) == i);
            end
          end
        end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
          aw_ready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          b_valid_d = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: data and response are captured on the address handshake edge.
  always_comb begin
    r_state_d  = r_state;
    ar_ready_d = 1'b0;
    r_valid_d  = r_valid;
    r_data_d   = r_data;
    r_resp_d   = r_resp;
    case (r_state)
      R_IDLE: begin
        if (ar_ready) begin
          if (S_AXI_ARVALID) begin
            r_state_d = R_DATA;
            r_valid_d = 1'b1;
            r_data_d  = rd_word;
            r_resp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end else if (S_AXI_ARVALID) begin
          ar_ready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          r_valid_d = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      aw_ready <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_resp   <= RESP_OKAY;
      r_data   <= '0;
      wr_pulse <= '0;
    end else begin
      w_state  <= w_state_d;
      r_state  <= r_state_d;
      aw_ready <= aw_ready_d;
      b_valid  <= b_valid_d;
      b_resp   <= b_resp_d;
      ar_ready <= ar_ready_d;
      r_valid  <= r_valid_d;
      r_resp   <= r_resp_d;
      r_data   <= r_data_d;
      wr_pulse <= wr_pulse_d;
    end
  end

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = aw_ready;
  assign S_AXI_BVALID  = b_valid;
  assign S_AXI_BRESP   = b_resp;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RRESP   = r_resp;
  assign S_AXI_RDATA   = r_data;

endmodule

// File: tb/tb_vga_axi_regfile.sv
// Bench for vga_axi_regfile: directed vector table, stall/reset/collision sequences and
// randomized traffic checked against an array-based register model.
module tb_vga_axi_regfile;
  localparam int DW  = 32;
  localparam int AW  = 7;
  localparam int NR  = 16;
  localparam int NRO = 4;
  localparam int NRW = NR - NRO;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    awaddr, araddr;
  logic [2:0]       awprot, arprot;
  logic             awvalid, awready, wvalid, wready, bvalid, bready;
  logic             arvalid, arready, rvalid, rready;
  logic [DW-1:0]    wdata, rdata;
  logic [DW/8-1:0]  wstrb;
  logic [1:0]       bresp, rresp;
  logic [NR*DW-1:0] ctrl_regs;
  logic [NRO*DW-1:0] status_in;
  logic [NR-1:0]    wr_pulse;
  logic [31:0]      st [NRO];

  assign status_in = {st[3], st[2], st[1], st[0]};

  vga_axi_regfile #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR), .NUM_RO_REGS(NRO)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_regs(ctrl_regs), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  int n_vec = 0;
  int n_bad = 0;
  int pulse_cnt [NR] = '{default: 0};
  logic [31:0] model_regs [NRW];

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return awready;
      1:       return bvalid;
      2:       return arready;
      default: return rvalid;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name);
    int n = 0;
    while (!sig(which) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: still 0 after 50 cycles, expected 1", name);
    end
  endtask

  function automatic int pulse_sum();
    int s = 0;
    foreach (pulse_cnt[i]) s += pulse_cnt[i];
    return s;
  endfunction

  // Reference model: register index is the word address; lanes update where strobes are set.
  function automatic logic [1:0] model_write(input logic [6:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    int idx = int'(a) / 4;
    if (idx >= NRW) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) model_regs[idx][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [1:0] model_read(input logic [6:0] a, output logic [31:0] d);
    int idx = int'(a) / 4;
    if (idx < NRW) begin d = model_regs[idx]; return 2'b00; end
    if (idx < NR)  begin d = st[idx-NRW];     return 2'b00; end
    d = 32'h0;
    return 2'b10;
  endfunction

  task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int dly, output logic [1:0] resp);
    @(posedge clk); #1;
    awaddr = a; awprot = 3'($urandom_range(0, 7)); wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    wait_for(0, "awready");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_for(1, "bvalid");
    repeat (dly) begin @(posedge clk); #1; end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [6:0] a, input int dly, output logic [31:0] d,
                          output logic [1:0] resp);
    @(posedge clk); #1;
    araddr = a; arprot = 3'($urandom_range(0, 7)); arvalid = 1'b1; rready = 1'b0;
    wait_for(2, "arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    wait_for(3, "rvalid");
    repeat (dly) begin @(posedge clk); #1; end
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic run_op(input string tag, input bit wr, input logic [6:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int dly, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp);
    logic [1:0]  resp;
    logic [31:0] rd;
    int idx, tot0, reg0;
    bit exp_p;
    idx   = int'(a) / 4;
    tot0  = pulse_sum();
    reg0  = (idx < NR) ? pulse_cnt[idx] : 0;
    exp_p = wr && (exp_resp == 2'b00);
    if (wr) begin
      axi_write(a, d, s, dly, resp);
      check({tag, "_bresp"}, 64'(resp), 64'(exp_resp));
    end else begin
      axi_read(a, dly, rd, resp);
      check({tag, "_rresp"}, 64'(resp), 64'(exp_resp));
      check({tag, "_rdata"}, 64'(rd), 64'(exp_data));
    end
    check({tag, "_pulses"}, 64'(pulse_sum() - tot0), 64'(exp_p));
    if (exp_p) check({tag, "_pulse_idx"}, 64'(pulse_cnt[idx] - reg0), 64'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t        tbl [$];
  logic [1:0]  r1, r2, er;
  logic [31:0] d2, ed;

  initial begin
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    st[0] = 32'hDEAD0001; st[1] = 32'h0BAD0002; st[2] = 32'h12345678; st[3] = 32'h5555AAAA;
    foreach (model_regs[i]) model_regs[i] = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 64'(awready), 0);
    check("rst_wready",  64'(wready), 0);
    check("rst_bvalid",  64'(bvalid), 0);
    check("rst_bresp",   64'(bresp), 0);
    check("rst_arready", 64'(arready), 0);
    check("rst_rvalid",  64'(rvalid), 0);
    check("rst_rresp",   64'(rresp), 0);
    check("rst_rdata",   64'(rdata), 0);
    check("rst_wr_pulse", 64'(wr_pulse), 0);
    check("rst_regs",    64'(|ctrl_regs[NRW*DW-1:0]), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    tbl.push_back('{1'b1, 7'h00, 32'h00000001, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{1'b1, 7'h04, 32'h00000002, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{1'b1, 7'h08, 32'h00000003, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{1'b1, 7'h0C, 32'h00000004, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 7'h00, 32'h0, 4'h0, 32'h00000001, 2'b00});
    tbl.push_back('{1'b0, 7'h04, 32'h0, 4'h0, 32'h00000002, 2'b00});
    tbl.push_back('{1'b0, 7'h08, 32'h0, 4'h0, 32'h00000003, 2'b00});
    tbl.push_back('{1'b0, 7'h0C, 32'h0, 4'h0, 32'h00000004, 2'b00});
    tbl.push_back('{1'b1, 7'h00, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00});
    tbl.push_back('{1'b1, 7'h00, 32'h000000AB, 4'h1, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 7'h00, 32'h0, 4'h0, 32'hFFFFFFAB, 2'b00});
    tbl.push_back('{1'b1, 7'h30, 32'h00001234, 4'hF, 32'h0, 2'b10});
    tbl.push_back('{1'b0, 7'h30, 32'h0, 4'h0, 32'hDEAD0001, 2'b00});
    tbl.push_back('{1'b0, 7'h40, 32'h0, 4'h0, 32'h00000000, 2'b10});
    tbl.push_back('{1'b1, 7'h40, 32'h00000BAD, 4'hF, 32'h0, 2'b10});
    tbl.push_back('{1'b1, 7'h08, 32'hCAFEF00D, 4'h0, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 7'h0A, 32'h0, 4'h0, 32'h00000003, 2'b00});
    tbl.push_back('{1'b0, 7'h3C, 32'h0, 4'h0, 32'h5555AAAA, 2'b00});
    tbl.push_back('{1'b1, 7'h2E, 32'h89ABCDEF, 4'hA, 32'h0, 2'b00});
    tbl.push_back('{1'b0, 7'h2C, 32'h0, 4'h0, 32'h8900CD00, 2'b00});
    tbl.push_back('{1'b0, 7'h7C, 32'h0, 4'h0, 32'h00000000, 2'b10});

    foreach (tbl[i]) begin
      if (tbl[i].wr) void'(model_write(tbl[i].addr, tbl[i].data, tbl[i].strb));
      run_op($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb,
             i % 3, tbl[i].exp_data, tbl[i].exp_resp);
    end
    check("ctrl_reg0", 64'(ctrl_regs[31:0]), 64'h00000000FFFFFFAB);

    // Same-cycle read and write of one register: read must see the old value.
    fork
      axi_write(7'h04, 32'h00000077, 4'hF, 0, r1);
      axi_read(7'h04, 0, d2, r2);
    join
    void'(model_write(7'h04, 32'h00000077, 4'hF));
    check("collide_bresp", 64'(r1), 0);
    check("collide_rresp", 64'(r2), 0);
    check("collide_rdata", 64'(d2), 64'h2);
    run_op("collide_after", 1'b0, 7'h04, 32'h0, 4'h0, 0, 32'h00000077, 2'b00);

    // Write response stall with a second request pending.
    @(posedge clk); #1;
    awaddr = 7'h14; wdata = 32'h11112222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    wait_for(0, "stall_awready");
    @(posedge clk); #1;
    awaddr = 7'h18; wdata = 32'h33334444;
    void'(model_write(7'h14, 32'h11112222, 4'hF));
    for (int k = 0; k < 10; k++) begin
      check("stall_bvalid", 64'(bvalid), 1);
      check("stall_bresp", 64'(bresp), 0);
      check("stall_no_aw", 64'(awready), 0);
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("stall_b_done", 64'(bvalid), 0);
    er = model_read(7'h18, ed);
    run_op("stall_w_unused", 1'b0, 7'h18, 32'h0, 4'h0, 0, ed, er);

    // Read data stall with a second request pending.
    @(posedge clk); #1;
    araddr = 7'h14; arvalid = 1'b1; rready = 1'b0;
    wait_for(2, "stall_arready");
    @(posedge clk); #1;
    araddr = 7'h30;
    for (int k = 0; k < 10; k++) begin
      check("stall_rvalid", 64'(rvalid), 1);
      check("stall_rdata", 64'(rdata), 64'h11112222);
      check("stall_rresp", 64'(rresp), 0);
      check("stall_no_ar", 64'(arready), 0);
      @(posedge clk); #1;
    end
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("stall_r_done", 64'(rvalid), 0);

    // Reset while a write response is pending.
    @(posedge clk); #1;
    awaddr = 7'h10; wdata = 32'h5A5A5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    wait_for(0, "rst_awready_mid");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("rst_pre_bvalid", 64'(bvalid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_bvalid_drop", 64'(bvalid), 0);
    check("rst_regs_clear", 64'(|ctrl_regs[NRW*DW-1:0]), 0);
    foreach (model_regs[i]) model_regs[i] = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(model_write(7'h10, 32'h00C0FFEE, 4'hF));
    run_op("post_rst_wr", 1'b1, 7'h10, 32'h00C0FFEE, 4'hF, 0, 32'h0, 2'b00);
    run_op("post_rst_rd", 1'b0, 7'h10, 32'h0, 4'h0, 0, 32'h00C0FFEE, 2'b00);
    run_op("post_rst_rd0", 1'b0, 7'h00, 32'h0, 4'h0, 0, 32'h00000000, 2'b00);

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      bit          wr;
      logic [6:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      int          dly;
      wr  = 1'($urandom_range(0, 1));
      a   = 7'($urandom_range(0, 8'h4F));
      d   = $urandom;
      s   = 4'($urandom_range(0, 15));
      dly = int'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) st[$urandom_range(0, 3)] = $urandom;
      if (wr) begin
        er = model_write(a, d, s);
        run_op($sformatf("rnd%0d", k), 1'b1, a, d, s, dly, 32'h0, er);
      end else begin
        er = model_read(a, ed);
        run_op($sformatf("rnd%0d", k), 1'b0, a, 32'h0, 4'h0, dly, ed, er);
      end
    end
    for (int i = 0; i < NRW; i++) begin
      check($sformatf("final_reg%0d", i), 64'(ctrl_regs[i*DW +: DW]), 64'(model_regs[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
